div_r4_param: RTL and testbench

DIV_R4_PARAM -- requirements
Module: div_r4_param

---
 rtl/div_r4_param.sv | 194 +++++++++++++++++++
 tb/tb_div_r4_param.sv | 407 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_r4_param.sv
// Radix-4 restoring divider, signed or unsigned, WIDTH/2 iterations.
// Result is {remainder, quotient}; divide-by-zero short-circuits.
module div_r4_param #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               start_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o,
  output logic               busy_o,
  output logic               div_zero_o
);

  localparam int HALF = WIDTH / 2;
  localparam int CW   = $clog2(HALF) + 1;
  localparam logic [CW-1:0] LAST = CW'(HALF - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_BUSY,
    S_FIX,
    S_DZERO,
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   quo_q, quo_d;
  logic [WIDTH-1:0]   dsr_q, dsr_d;
  logic [WIDTH-1:0]   op1_q, op1_d;
  logic               sgn_q, sgn_d;
  logic               s1_q, s1_d;
  logic               s2_q, s2_d;
  logic [2*WIDTH-1:0] res_q, res_d;
  logic               rdy_q, rdy_d;
  logic               dz_q, dz_d;

  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH-1:0]   q_fix, r_fix;
  logic [WIDTH+1:0]   r4, m1, m2, m3;
  logic [WIDTH-1:0]   t1, t2, t3, rsel;
  logic [1:0]         qdig;

  assign a_mag = (signed_div_i && opdata1_i[WIDTH-1])
               ? -opdata1_i : opdata1_i;
  assign b_mag = (signed_div_i && opdata2_i[WIDTH-1])
               ? -opdata2_i : opdata2_i;
  assign q_fix = (sgn_q && (s1_q ^ s2_q)) ? -quo_q : quo_q;
  assign r_fix = (sgn_q && s1_q) ? -rem_q : rem_q;

  // One radix-4 step: pick the largest of 3d/2d/d that fits.
  always_comb begin
    r4 = {rem_q, quo_q[WIDTH-1 -: 2]};
    m1 = {2'b00, dsr_q};
    m2 = {1'b0, dsr_q, 1'b0};
    m3 = m1 + m2;
    t1 = r4[WIDTH-1:0] - m1[WIDTH-1:0];
    t2 = r4[WIDTH-1:0] - m2[WIDTH-1:0];
    t3 = r4[WIDTH-1:0] - m3[WIDTH-1:0];
    qdig = 2'd0;
    rsel = r4[WIDTH-1:0];
    if (r4 >= m3) begin
      qdig = 2'd3;
      rsel = t3;
    end else if (r4 >= m2) begin
      qdig = 2'd2;
      rsel = t2;
    end else if (r4 >= m1) begin
      qdig = 2'd1;
      rsel = t1;
    end
  end

  // Next-state and output decode; annul overrides everything.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dsr_d   = dsr_q;
    op1_d   = op1_q;
    sgn_d   = sgn_q;
    s1_d    = s1_q;
    s2_d    = s2_q;
    res_d   = res_q;
    rdy_d   = rdy_q;
    dz_d    = dz_q;
    if (annul_i && state_q != S_IDLE) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      res_d   = '0;
      rdy_d   = 1'b0;
      dz_d    = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          res_d = '0;
          rdy_d = 1'b0;
          dz_d  = 1'b0;
          if (start_i && !annul_i) begin
            op1_d = opdata1_i;
            sgn_d = signed_div_i;
            s1_d  = opdata1_i[WIDTH-1];
            s2_d  = opdata2_i[WIDTH-1];
            rem_d = '0;
            quo_d = a_mag;
            dsr_d = b_mag;
            cnt_d = '0;
            state_d = (opdata2_i == '0) ? S_DZERO : S_BUSY;
          end
        end
        S_BUSY: begin
          rem_d = rsel;
          quo_d = {quo_q[WIDTH-3:0], qdig};
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            state_d = S_FIX;
          end
        end
        S_FIX: begin
          res_d   = {r_fix, q_fix};
          rdy_d   = 1'b1;
          dz_d    = 1'b0;
          state_d = S_DONE;
        end
        S_DZERO: begin
          res_d   = {op1_q, {WIDTH{1'b1}}};
          rdy_d   = 1'b1;
          dz_d    = 1'b1;
          state_d = S_DONE;
        end
        S_DONE: begin
          if (!start_i) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            res_d   = '0;
            rdy_d   = 1'b0;
            dz_d    = 1'b0;
          end
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
          res_d   = '0;
          rdy_d   = 1'b0;
          dz_d    = 1'b0;
        end
      endcase
    end
  end

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dsr_q   <= '0;
      op1_q   <= '0;
      sgn_q   <= 1'b0;
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      res_q   <= '0;
      rdy_q   <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dsr_q   <= dsr_d;
      op1_q   <= op1_d;
      sgn_q   <= sgn_d;
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      res_q   <= res_d;
      rdy_q   <= rdy_d;
      dz_q    <= dz_d;
    end
  end

  assign result_o   = res_q;
  assign ready_o    = rdy_q;
  assign div_zero_o = dz_q;
  assign busy_o     = (state_q != S_IDLE);

endmodule

// File: tb/tb_div_r4_param.sv
// Randomized bench for div_r4_param at WIDTH=32 and WIDTH=8.
// Expected values come from plain integer division.
module tb_div_r4_param;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        sd32 = 1'b0, st32 = 1'b0, an32 = 1'b0;
  logic [31:0] a32 = '0, b32 = '0;
  logic [63:0] res32;
  logic        rdy32, busy32, dz32;

  logic        sd8 = 1'b0, st8 = 1'b0, an8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic [15:0] res8;
  logic        rdy8, busy8, dz8;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  div_r4_param #(.WIDTH(32)) dut32 (
    .clk(clk), .rst(rst),
    .signed_div_i(sd32),
    .opdata1_i(a32), .opdata2_i(b32),
    .start_i(st32), .annul_i(an32),
    .result_o(res32), .ready_o(rdy32),
    .busy_o(busy32), .div_zero_o(dz32)
  );

  div_r4_param #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst),
    .signed_div_i(sd8),
    .opdata1_i(a8), .opdata2_i(b8),
    .start_i(st8), .annul_i(an8),
    .result_o(res8), .ready_o(rdy8),
    .busy_o(busy8), .div_zero_o(dz8)
  );

  // Reference: {rem, quo} from integer division, w-bit fields.
  function automatic logic [63:0] model(
    input int w, input bit s,
    input logic [31:0] a, input logic [31:0] b
  );
    longint sa, sb, q, r;
    logic [63:0] m;
    m = (64'h1 << w) - 64'h1;
    if (b == 32'h0)
      return ((64'(a) & m) << w) | m;
    sa = longint'({32'h0, a});
    sb = longint'({32'h0, b});
    if (s && a[w-1]) sa = sa - (longint'(1) << w);
    if (s && b[w-1]) sb = sb - (longint'(1) << w);
    q = sa / sb;
    r = sa % sb;
    return ((64'(r) & m) << w) | (64'(q) & m);
  endfunction

  function automatic logic [31:0] pick(input int w);
    logic [31:0] v;
    int k;
    k = $urandom_range(0, 9);
    case (k)
      0: v = 32'h0;
      1: v = 32'h1;
      2: v = 32'hFFFF_FFFF;
      3: v = 32'h1 << (w - 1);
      4: v = (32'h1 << (w - 1)) - 32'h1;
      5: v = $urandom_range(0, 15);
      default: v = $urandom;
    endcase
    if (w < 32) v = v & ((32'h1 << w) - 32'h1);
    return v;
  endfunction

  // Full handshake on the 32-bit unit; operands scrambled after accept.
  task automatic op32(
    input bit s, input logic [31:0] a, input logic [31:0] b,
    output logic [63:0] res, output int lat,
    output logic dz, output bit hs_ok
  );
    @(negedge clk);
    sd32 = s; a32 = a; b32 = b; st32 = 1'b1;
    @(posedge clk); #1;
    a32 = $urandom; b32 = $urandom; sd32 = 1'($urandom);
    lat = -1;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (rdy32) begin
        lat = c;
        break;
      end
    end
    res = res32;
    dz = dz32;
    hs_ok = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      if (!rdy32 || res32 !== res || !busy32) hs_ok = 1'b0;
    end
    @(negedge clk);
    st32 = 1'b0;
    @(posedge clk); #1;
    if (res32 !== 64'h0 || rdy32 || dz32 || busy32) hs_ok = 1'b0;
  endtask

  task automatic op8(
    input bit s, input logic [7:0] a, input logic [7:0] b,
    output logic [15:0] res, output int lat, output logic dz
  );
    @(negedge clk);
    sd8 = s; a8 = a; b8 = b; st8 = 1'b1;
    @(posedge clk); #1;
    a8 = 8'($urandom); b8 = 8'($urandom);
    lat = -1;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      if (rdy8) begin
        lat = c;
        break;
      end
    end
    res = res8;
    dz = dz8;
    @(negedge clk);
    st8 = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (res32 !== 64'h0 || rdy32 !== 1'b0) begin
      bad++;
      $display("FAIL reset_out res=%h rdy=%b want 0/0", res32, rdy32);
    end
    total++;
    if (busy32 !== 1'b0 || dz32 !== 1'b0) begin
      bad++;
      $display("FAIL reset_busy busy=%b dz=%b want 0/0", busy32, dz32);
    end
    total++;
    if (busy8 !== 1'b0 || rdy8 !== 1'b0 || res8 !== 16'h0) begin
      bad++;
      $display("FAIL reset_w8 busy=%b rdy=%b res=%h want 0", busy8, rdy8, res8);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_directed;
    logic [63:0] r;
    int l;
    logic z;
    bit h;
    op32(1'b0, 32'd100, 32'd7, r, l, z, h);
    total++;
    if (l !== 17) begin
      bad++;
      $display("FAIL lat_100_7 got=%0d want=17", l);
    end
    total++;
    if (r !== {32'h2, 32'hE} || z !== 1'b0) begin
      bad++;
      $display("FAIL u100_7 got=%h dz=%b want=%h dz=0", r, z, {32'h2, 32'hE});
    end
    total++;
    if (!h) begin
      bad++;
      $display("FAIL hold_clear_100_7 got=0 want=1");
    end
    op32(1'b1, 32'hFFFF_FFF9, 32'd2, r, l, z, h);
    total++;
    if (r !== {32'hFFFF_FFFF, 32'hFFFF_FFFD}) begin
      bad++;
      $display("FAIL s_m7_2 got=%h want=ffffffff_fffffffd", r);
    end
    op32(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, r, l, z, h);
    total++;
    if (r !== {32'h0, 32'h8000_0000}) begin
      bad++;
      $display("FAIL s_min_m1 got=%h want=00000000_80000000", r);
    end
    op32(1'b0, 32'hFFFF_FFFF, 32'h1, r, l, z, h);
    total++;
    if (r !== {32'h0, 32'hFFFF_FFFF}) begin
      bad++;
      $display("FAIL u_max_1 got=%h want=00000000_ffffffff", r);
    end
  endtask

  task automatic test_div_zero;
    logic [63:0] r;
    int l;
    logic z;
    bit h;
    op32(1'b0, 32'd5, 32'd0, r, l, z, h);
    total++;
    if (l !== 1 || z !== 1'b1) begin
      bad++;
      $display("FAIL dz_timing lat=%0d dz=%b want 1/1", l, z);
    end
    total++;
    if (r !== {32'h5, 32'hFFFF_FFFF}) begin
      bad++;
      $display("FAIL dz_result got=%h want=00000005_ffffffff", r);
    end
    total++;
    if (!h) begin
      bad++;
      $display("FAIL dz_clear got=0 want=1");
    end
    op32(1'b1, 32'hFFFF_FFFD, 32'd0, r, l, z, h);
    total++;
    if (r !== {32'hFFFF_FFFD, 32'hFFFF_FFFF} || z !== 1'b1) begin
      bad++;
      $display("FAIL dz_signed got=%h dz=%b want=fffffffd_ffffffff dz=1", r, z);
    end
  endtask

  task automatic test_annul;
    logic [63:0] r;
    int l;
    logic z;
    bit h;
    bit seen;
    seen = 1'b0;
    @(negedge clk);
    sd32 = 1'b0; a32 = 32'd100; b32 = 32'd7; st32 = 1'b1;
    @(posedge clk); #1;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      if (rdy32) seen = 1'b1;
    end
    @(negedge clk);
    an32 = 1'b1; st32 = 1'b0;
    @(posedge clk); #1;
    total++;
    if (busy32 !== 1'b0 || rdy32 !== 1'b0) begin
      bad++;
      $display("FAIL annul_idle busy=%b rdy=%b want 0/0", busy32, rdy32);
    end
    @(negedge clk);
    an32 = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (rdy32 || busy32) seen = 1'b1;
    end
    total++;
    if (seen) begin
      bad++;
      $display("FAIL annul_noready got=1 want=0");
    end
    op32(1'b0, 32'd9, 32'd3, r, l, z, h);
    total++;
    if (r !== {32'h0, 32'h3} || l !== 17) begin
      bad++;
      $display("FAIL after_annul got=%h lat=%0d want=00000000_00000003 lat=17", r, l);
    end
    @(negedge clk);
    an32 = 1'b1; st32 = 1'b1; a32 = 32'd9; b32 = 32'd3;
    seen = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      if (busy32 || rdy32) seen = 1'b1;
    end
    total++;
    if (seen) begin
      bad++;
      $display("FAIL annul_start_idle busy_seen=1 want=0");
    end
    @(negedge clk);
    an32 = 1'b0; st32 = 1'b0;
  endtask

  task automatic test_reset_mid;
    logic [63:0] r;
    int l;
    logic z;
    bit h;
    @(negedge clk);
    sd32 = 1'b0; a32 = 32'd50; b32 = 32'd5; st32 = 1'b1;
    @(posedge clk);
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    total++;
    if (busy32 !== 1'b0 || res32 !== 64'h0) begin
      bad++;
      $display("FAIL rst_busy busy=%b res=%h want 0", busy32, res32);
    end
    @(negedge clk);
    rst = 1'b0; st32 = 1'b0;
    @(negedge clk);
    a32 = 32'd50; b32 = 32'd5; st32 = 1'b1;
    l = -1;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (rdy32) begin
        l = c;
        break;
      end
    end
    #1 rst = 1'b1;
    #1;
    total++;
    if (l < 0 || res32 !== 64'h0 || rdy32 || dz32 || busy32) begin
      bad++;
      $display("FAIL rst_done lat=%0d res=%h rdy=%b want res=0 rdy=0", l, res32, rdy32);
    end
    @(negedge clk);
    rst = 1'b0; st32 = 1'b0;
    op32(1'b0, 32'd9, 32'd3, r, l, z, h);
    total++;
    if (r !== {32'h0, 32'h3} || l !== 17 || !h) begin
      bad++;
      $display("FAIL after_rst got=%h lat=%0d want=00000000_00000003 lat=17", r, l);
    end
  endtask

  task automatic test_back_to_back;
    logic [63:0] r1, r2;
    int l1, l2;
    logic z1, z2;
    bit h1, h2;
    op32(1'b1, 32'hFFFF_FF9C, 32'd7, r1, l1, z1, h1);
    op32(1'b0, 32'd1000, 32'd33, r2, l2, z2, h2);
    total++;
    if (r1 !== model(32, 1'b1, 32'hFFFF_FF9C, 32'd7) || !h1) begin
      bad++;
      $display("FAIL b2b_first got=%h want=%h",
               r1, model(32, 1'b1, 32'hFFFF_FF9C, 32'd7));
    end
    total++;
    if (r2 !== {32'd10, 32'd30} || l2 !== 17 || !h2) begin
      bad++;
      $display("FAIL b2b_second got=%h lat=%0d want=0000000a_0000001e", r2, l2);
    end
  endtask

  task automatic test_random;
    logic [63:0] r, e;
    logic [31:0] a, b;
    int l;
    logic z;
    bit h, s;
    for (int i = 0; i < 300; i++) begin
      a = pick(32);
      b = pick(32);
      s = 1'($urandom);
      e = model(32, s, a, b);
      op32(s, a, b, r, l, z, h);
      total++;
      if (r !== e || z !== (b == 32'h0) || !h ||
          l !== ((b == 32'h0) ? 1 : 17)) begin
        bad++;
        $display("FAIL rand32 s=%0d a=%h b=%h got=%h dz=%b lat=%0d want=%h",
                 s, a, b, r, z, l, e);
      end
    end
  endtask

  task automatic test_w8;
    logic [15:0] r;
    logic [63:0] e;
    logic [31:0] a, b;
    int l;
    logic z;
    bit s;
    op8(1'b0, 8'hFF, 8'h10, r, l, z);
    total++;
    if (r !== 16'h0F0F || l !== 5 || z !== 1'b0) begin
      bad++;
      $display("FAIL w8_ff_10 got=%h lat=%0d want=0f0f lat=5", r, l);
    end
    for (int i = 0; i < 100; i++) begin
      a = pick(8);
      b = pick(8);
      s = 1'($urandom);
      e = model(8, s, a, b);
      op8(s, a[7:0], b[7:0], r, l, z);
      total++;
      if (r !== e[15:0] || z !== (b == 32'h0) ||
          l !== ((b == 32'h0) ? 1 : 5)) begin
        bad++;
        $display("FAIL rand8 s=%0d a=%h b=%h got=%h lat=%0d want=%h",
                 s, a[7:0], b[7:0], r, l, e[15:0]);
      end
    end
  endtask

  initial begin
    test_reset;
    test_directed;
    test_div_zero;
    test_annul;
    test_reset_mid;
    test_back_to_back;
    test_random;
    test_w8;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
